// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   instruction_s : instruction word as delivered by the instruction memory
//   fetch_state_e : fetch sequencer states
//   fetch_resp_s  : instruction/PC pair held while decode is stalled
//   sat_inc32     : saturating 32-bit increment for the optional perf counters
package instr_fetch_pkg;

   localparam int unsigned instr_width      = 32;
   localparam int unsigned fetch_addr_width = 10;
   localparam int unsigned perf_width       = 32;

   typedef struct packed {
      logic [instr_width-1:0] word;
   } instruction_s;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      instruction_s                instr;
      logic [fetch_addr_width-1:0] pc;
   } fetch_resp_s;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [perf_width-1:0] sat_inc32(input logic [perf_width-1:0] v);
      return (v == {perf_width{1'b1}}) ? v : v + perf_width'(1);
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry capture/drain register used to park a fetched instruction while
// decode is not ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop the held entry (highest priority)
//   fill       : capture fill_data and mark the entry valid
//   drain      : release the held entry
//   fill_data  : entry to capture
//   valid      : entry held
//   data       : held entry
module fetch_skid_buf
   import instr_fetch_pkg::*;
#(
   parameter type entry_t = fetch_resp_s
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush,
   input  logic   fill,
   input  logic   drain,
   input  entry_t fill_data,
   output logic   valid,
   output entry_t data
);

   // Flush beats fill beats drain; a fill never coincides with a drain in
   // the fetch unit because fill requires the buffer to be empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (fill) begin
         valid <= 1'b1;
         data  <= fill_data;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: read-side initiator for a synchronous instruction
// memory with one cycle of read latency. Issues sequential addresses, pairs
// each returned word with its PC and hands it to decode over valid/ready.
// A one-entry skid register plus holding the memory address on the pending
// PC absorbs decode stalls without losing the word in flight.
//
// Optional feature (macro INSTR_FETCH_PERF_EN): adds saturating 32-bit
// fetch_count_o (valid&ready transfers) and stall_count_o (valid&!ready
// cycles).
//
// Ports:
//   clk, n_reset_i          : clock, asynchronous active-low reset
//   start_i, start_pc_i     : begin fetching at start_pc_i
//   halt_i                  : flush and return to IDLE
//   redirect_v_i/_pc_i      : branch/jump redirect
//   imem_addr_o, imem_wen_o : memory read address, write enable (always 0)
//   imem_instr_i            : memory data for last cycle's address
//   fetch_valid_o/_ready_i  : handshake to decode
//   fetch_instr_o/_pc_o     : instruction and its PC
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned addr_width_p = fetch_addr_width
) (
   input  logic                    clk,
   input  logic                    n_reset_i,
   input  logic                    start_i,
   input  logic [addr_width_p-1:0] start_pc_i,
   input  logic                    halt_i,
   input  logic                    redirect_v_i,
   input  logic [addr_width_p-1:0] redirect_pc_i,
   output logic [addr_width_p-1:0] imem_addr_o,
   output logic                    imem_wen_o,
   input  instruction_s            imem_instr_i,
   output logic                    fetch_valid_o,
   input  logic                    fetch_ready_i,
   output instruction_s            fetch_instr_o,
   output logic [addr_width_p-1:0] fetch_pc_o
`ifdef INSTR_FETCH_PERF_EN
   ,
   output logic [perf_width-1:0]   fetch_count_o,
   output logic [perf_width-1:0]   stall_count_o
`endif
);

   typedef struct packed {
      instruction_s            instr;
      logic [addr_width_p-1:0] pc;
   } resp_t;

   fetch_state_e            state;
   logic [addr_width_p-1:0] pc_r;
   logic                    resp_v_r;
   logic [addr_width_p-1:0] resp_pc_r;

   logic                    skid_v_r;
   resp_t                   skid_q;
   resp_t                   resp_cur;

   logic                    in_run;
   logic                    flush;
   logic                    issue;
   logic                    skid_fill;
   logic                    skid_drain;
   logic [addr_width_p-1:0] flush_pc;

   assign in_run = (state == RUN);

   // start_i while running behaves like a redirect to start_pc_i.
   assign flush  = in_run & (halt_i | redirect_v_i | start_i);

   // No new address while the skid is occupied: two entries already in flight.
   assign issue  = in_run & ~flush & ~skid_v_r;

   // halt keeps the current PC; redirect wins over a concurrent start.
   always_comb begin
      flush_pc = pc_r;
      if (halt_i)            flush_pc = pc_r;
      else if (redirect_v_i) flush_pc = redirect_pc_i;
      else if (start_i)      flush_pc = start_pc_i;
   end

   // Word returned this cycle belongs to the address issued (or held) last cycle.
   assign resp_cur = {imem_instr_i, resp_pc_r};

   assign skid_fill  = resp_v_r & ~skid_v_r & ~fetch_ready_i;
   assign skid_drain = skid_v_r & fetch_ready_i;

   // Sequencer and response tracking.
   always_ff @(posedge clk or negedge n_reset_i) begin
      if (!n_reset_i) begin
         state     <= IDLE;
         pc_r      <= '0;
         resp_v_r  <= 1'b0;
         resp_pc_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  pc_r  <= start_pc_i;
                  state <= RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  resp_v_r <= 1'b0;
                  pc_r     <= flush_pc;
                  if (halt_i) state <= IDLE;
               end else if (issue) begin
                  resp_v_r  <= 1'b1;
                  resp_pc_r <= pc_r;
                  pc_r      <= pc_r + addr_width_p'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fetch_skid_buf #(
      .entry_t (resp_t)
   ) u_skid (
      .clk       (clk),
      .rst_n     (n_reset_i),
      .flush     (flush),
      .fill      (skid_fill),
      .drain     (skid_drain),
      .fill_data (resp_cur),
      .valid     (skid_v_r),
      .data      (skid_q)
   );

   // While the skid is full the memory re-reads the pending PC so its word
   // is still on imem_instr_i when the skid drains.
   assign imem_addr_o = skid_v_r ? resp_pc_r : pc_r;
   assign imem_wen_o  = 1'b0;

   assign fetch_valid_o = (skid_v_r | resp_v_r) & ~redirect_v_i & ~halt_i & ~start_i;
   assign fetch_instr_o = skid_v_r ? skid_q.instr : imem_instr_i;
   assign fetch_pc_o    = skid_v_r ? skid_q.pc    : resp_pc_r;

`ifdef INSTR_FETCH_PERF_EN
   logic [perf_width-1:0] fetch_cnt_r;
   logic [perf_width-1:0] stall_cnt_r;

   // Transfer and stall counters, saturating.
   always_ff @(posedge clk or negedge n_reset_i) begin
      if (!n_reset_i) begin
         fetch_cnt_r <= '0;
         stall_cnt_r <= '0;
      end else begin
         if (fetch_valid_o & fetch_ready_i)  fetch_cnt_r <= sat_inc32(fetch_cnt_r);
         if (fetch_valid_o & ~fetch_ready_i) stall_cnt_r <= sat_inc32(stall_cnt_r);
      end
   end

   assign fetch_count_o = fetch_cnt_r;
   assign stall_count_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random stimulus, all
// checked against a queue-based model of the fetch pipeline.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int unsigned aw    = 10;
   localparam int unsigned depth = 1 << aw;

   logic           clk;
   logic           n_reset;
   logic           start;
   logic [aw-1:0]  start_pc;
   logic           halt;
   logic           redir;
   logic [aw-1:0]  redir_pc;
   logic [aw-1:0]  imem_addr;
   logic           imem_wen;
   instruction_s   imem_instr;
   logic           fetch_valid;
   logic           fetch_ready;
   instruction_s   fetch_instr;
   logic [aw-1:0]  fetch_pc;
`ifdef INSTR_FETCH_PERF_EN
   logic [31:0]    fetch_count;
   logic [31:0]    stall_count;
`endif

   instr_fetch #(.addr_width_p(aw)) dut (
      .clk           (clk),
      .n_reset_i     (n_reset),
      .start_i       (start),
      .start_pc_i    (start_pc),
      .halt_i        (halt),
      .redirect_v_i  (redir),
      .redirect_pc_i (redir_pc),
      .imem_addr_o   (imem_addr),
      .imem_wen_o    (imem_wen),
      .imem_instr_i  (imem_instr),
      .fetch_valid_o (fetch_valid),
      .fetch_ready_i (fetch_ready),
      .fetch_instr_o (fetch_instr),
      .fetch_pc_o    (fetch_pc)
`ifdef INSTR_FETCH_PERF_EN
      ,
      .fetch_count_o (fetch_count),
      .stall_count_o (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory, one cycle read latency.
   logic [31:0] mem [depth];
   always @(posedge clk) imem_instr.word <= mem[imem_addr];

   int n_vec = 0;
   int n_err = 0;

   // Reference model: PCs in flight (oldest first), next PC to fetch, state.
   int unsigned m_q[$];
   int unsigned m_next;
   bit          m_run;
   longint      m_fc;
   longint      m_sc;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input bit s, input int unsigned spc, input bit h, input bit r,
                       input int unsigned rpc, input bit rdy);
      bit          exp_v;
      int unsigned exp_addr;
      int unsigned sz;
      @(negedge clk);
      start    = s;
      start_pc = aw'(spc);
      halt     = h;
      redir    = r;
      redir_pc = aw'(rpc);
      fetch_ready = rdy;
      #1;
      sz       = m_q.size();
      exp_v    = (sz > 0) && !h && !r && !s;
      exp_addr = (sz == 2) ? m_q[1] : m_next;
      check_eq("valid", 64'(fetch_valid), 64'(exp_v));
      check_eq("imem_addr", 64'(imem_addr), 64'(exp_addr));
      check_eq("imem_wen", 64'(imem_wen), 64'd0);
      if (exp_v) begin
         check_eq("fetch_pc", 64'(fetch_pc), 64'(m_q[0]));
         check_eq("fetch_instr", 64'(fetch_instr.word), 64'(mem[m_q[0]]));
      end
`ifdef INSTR_FETCH_PERF_EN
      check_eq("fetch_count", 64'(fetch_count), 64'(m_fc));
      check_eq("stall_count", 64'(stall_count), 64'(m_sc));
      if (exp_v && rdy)  m_fc++;
      if (exp_v && !rdy) m_sc++;
`endif
      if (!m_run) begin
         if (s) begin
            m_run  = 1'b1;
            m_next = spc % depth;
         end
      end else if (h) begin
         m_q.delete();
         m_run = 1'b0;
      end else if (r) begin
         m_q.delete();
         m_next = rpc % depth;
      end else if (s) begin
         m_q.delete();
         m_next = spc % depth;
      end else begin
         if (sz > 0 && rdy) void'(m_q.pop_front());
         if (sz < 2) begin
            m_q.push_back(m_next);
            m_next = (m_next + 1) % depth;
         end
      end
   endtask

   task automatic idle_steps(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      n_reset     = 1'b0;
      start       = 1'b0;
      halt        = 1'b0;
      redir       = 1'b0;
      fetch_ready = 1'b1;
      #1;
      check_eq("rst_valid", 64'(fetch_valid), 64'd0);
      check_eq("rst_addr", 64'(imem_addr), 64'd0);
      check_eq("rst_wen", 64'(imem_wen), 64'd0);
`ifdef INSTR_FETCH_PERF_EN
      check_eq("rst_fetch_count", 64'(fetch_count), 64'd0);
      check_eq("rst_stall_count", 64'(stall_count), 64'd0);
`endif
      m_q.delete();
      m_run  = 1'b0;
      m_next = 0;
      m_fc   = 0;
      m_sc   = 0;
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit reached;
      bit s, h, r, rdy;
      for (int k = 0; k < int'(depth); k++) mem[k] = 32'h100 + 32'(k);
      n_reset = 1'b0; start = 1'b0; start_pc = '0; halt = 1'b0;
      redir = 1'b0; redir_pc = '0; fetch_ready = 1'b1;
      m_next = 0; m_run = 1'b0; m_fc = 0; m_sc = 0;

      apply_reset();

      // Sequential fetch from 0 with decode always ready.
      step(1, 0, 0, 0, 0, 1);
      idle_steps(6, 1);

      // Stall three cycles while pc 5 is presented.
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         if (m_q.size() > 0 && m_q[0] == 5) reached = 1'b1;
         else step(0, 0, 0, 0, 0, 1);
      end
      check_eq("reach_pc5", 64'(reached), 64'd1);
      idle_steps(3, 0);
      idle_steps(5, 1);

      // Start near the top of the address space: wraps to 0.
      step(1, depth - 2, 0, 0, 0, 1);
      idle_steps(6, 1);

      // Fill the skid, then redirect to 0x40.
      idle_steps(2, 0);
      check_eq("skid_full", 64'(m_q.size()), 64'd2);
      step(0, 0, 0, 1, 'h40, 1);
      idle_steps(5, 1);

      // Halt mid-stream, then restart at 0x10.
      step(0, 0, 1, 0, 0, 1);
      idle_steps(3, 1);
      step(1, 'h10, 0, 0, 0, 1);
      idle_steps(5, 1);

      // Reset during a stall with the skid full; stay idle until restarted.
      idle_steps(2, 0);
      apply_reset();
      idle_steps(4, 1);
      step(1, 'h20, 0, 0, 0, 1);
      idle_steps(4, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) == 0) apply_reset();
         s   = ($urandom_range(99) < 3);
         h   = ($urandom_range(99) < 2);
         r   = ($urandom_range(99) < 4) && !s;
         rdy = ($urandom_range(99) < 70);
         step(s, $urandom_range(depth - 1), h, r, $urandom_range(depth - 1), rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
